// File: rtl/cx4_bus_fetch.sv
// Burst fetch engine: issues single-byte reads to the PSRAM arbiter and buffers them in a show-ahead FIFO.
// Optional watchdog enabled by defining CX4_FETCH_TIMEOUT_EN (otherwise ERR is tied to 0).
module cx4_bus_fetch #(
    parameter int DEPTH_LOG2 = 3,
    parameter int LEN_W      = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [23:0]           CMD_ADDR,
    input  logic [LEN_W-1:0]      CMD_LEN,
    input  logic                  CMD_START,
    input  logic                  CMD_ABORT,
    output logic                  CMD_BUSY,
    output logic                  ERR,
    output logic [23:0]           BUS_ADDR,
    output logic                  BUS_RRQ,
    input  logic                  BUS_RDY,
    input  logic [7:0]            BUS_DI,
    output logic [7:0]            FIFO_DATA,
    output logic                  FIFO_VALID,
    input  logic                  FIFO_POP,
    output logic [DEPTH_LOG2:0]   FIFO_LEVEL
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;
    localparam int PW    = DEPTH_LOG2;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, STALL, DRAIN} state_t;

    state_t state, next_state;

    logic [23:0]      addr;
    logic [LEN_W-1:0] remain;
    logic             drain_lo;
    logic [7:0]       mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    level, level_next;
    logic             push, pop, flush, timeout;
    logic             has_room, last_byte, start_ok;

`ifdef CX4_FETCH_TIMEOUT_EN
    logic [7:0] wd_count;
    logic       err_q;
    logic       in_wait;

    assign in_wait = (state == WAIT_LO) || (state == WAIT_HI) || (state == DRAIN);
    assign timeout = in_wait && (wd_count == 8'hFF);
    assign ERR     = err_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wd_count <= '0;
            err_q    <= 1'b0;
        end else begin
            if (timeout)
                err_q <= 1'b1;
            if (!in_wait || (next_state != state))
                wd_count <= '0;
            else
                wd_count <= wd_count + 8'd1;
        end
    end
`else
    assign timeout = 1'b0;
    assign ERR     = 1'b0;
`endif

    // The space check uses the post-push/pop level, so the single in-flight byte always has a slot.
    always_comb begin
        flush      = CMD_ABORT || timeout;
        push       = (state == WAIT_HI) && BUS_RDY && !flush;
        pop        = FIFO_POP && (level != '0) && !flush;
        level_next = level + LW'(push) - LW'(pop);
        has_room   = level_next <= LW'(DEPTH - 1);
        last_byte  = remain == LEN_W'(1);
        start_ok   = CMD_START && !CMD_ABORT && (CMD_LEN != '0);
    end

    always_ff @(posedge CLK) begin
        if (RST)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_ok)
                    next_state = ISSUE;
            end
            ISSUE: begin
                next_state = CMD_ABORT ? IDLE : WAIT_LO;
            end
            WAIT_LO: begin
                if (CMD_ABORT)
                    next_state = DRAIN;
                else if (!BUS_RDY)
                    next_state = WAIT_HI;
            end
            WAIT_HI: begin
                // An abort on the very cycle data returns has nothing left to drain.
                if (CMD_ABORT)
                    next_state = BUS_RDY ? IDLE : DRAIN;
                else if (BUS_RDY) begin
                    if (last_byte)
                        next_state = IDLE;
                    else if (has_room)
                        next_state = ISSUE;
                    else
                        next_state = STALL;
                end
            end
            STALL: begin
                if (CMD_ABORT)
                    next_state = IDLE;
                else if (has_room)
                    next_state = ISSUE;
            end
            DRAIN: begin
                if (drain_lo && BUS_RDY)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (timeout)
            next_state = IDLE;
    end

    always_comb begin
        BUS_RRQ    = (state == ISSUE) && !CMD_ABORT;
        CMD_BUSY   = state != IDLE;
        BUS_ADDR   = addr;
        FIFO_LEVEL = level;
        FIFO_VALID = level != '0;
        FIFO_DATA  = FIFO_VALID ? mem[rd_ptr] : 8'h00;
    end

    // drain_lo records that the in-flight read has already dropped RDY, so DRAIN only waits for its rise.
    always_ff @(posedge CLK) begin
        if (RST) begin
            addr     <= '0;
            remain   <= '0;
            drain_lo <= 1'b0;
        end else begin
            if ((state == IDLE) && start_ok) begin
                addr   <= CMD_ADDR;
                remain <= CMD_LEN;
            end
            if (push) begin
                addr   <= addr + 24'd1;
                remain <= remain - LEN_W'(1);
            end
            if ((next_state == DRAIN) && (state != DRAIN))
                drain_lo <= (state == WAIT_HI) || !BUS_RDY;
            else if ((state == DRAIN) && !BUS_RDY)
                drain_lo <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            level <= level_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= BUS_DI;
    end

endmodule

// File: tb/tb_cx4_bus_fetch.sv
// Bench for cx4_bus_fetch: arbiter model returning addr[7:0], plus a queue-based FIFO scoreboard.
`timescale 1ns/1ps
module tb_cx4_bus_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] cmd_addr = '0;
    logic [15:0] cmd_len = '0;
    logic        cmd_start = 1'b0;
    logic        cmd_abort = 1'b0;
    logic        cmd_busy;
    logic        err;
    logic [23:0] bus_addr;
    logic        bus_rrq;
    logic        bus_rdy = 1'b1;
    logic [7:0]  bus_di = '0;
    logic [7:0]  fifo_data;
    logic        fifo_valid;
    logic        fifo_pop = 1'b0;
    logic [3:0]  fifo_level;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int          arb_lat = 7;
    logic        arb_hold = 1'b0;
    logic        arb_busy = 1'b0;
    logic        arb_deliver = 1'b0;
    int          arb_cnt = 0;
    logic [23:0] arb_addr = '0;
    int          rrq_count = 0;
    int          deliveries = 0;
    int          last_deliver_cyc = 0;
    logic [23:0] addr_log [$];
    logic [23:0] burst_base = '0;
    int          rrq_base = 0;

    logic [7:0]  model_q [$];
    logic [7:0]  popped [$];
    logic        cancelled = 1'b0;
    logic        ignore_delivery = 1'b0;

    cx4_bus_fetch dut (
        .CLK(clk), .RST(rst),
        .CMD_ADDR(cmd_addr), .CMD_LEN(cmd_len), .CMD_START(cmd_start), .CMD_ABORT(cmd_abort),
        .CMD_BUSY(cmd_busy), .ERR(err),
        .BUS_ADDR(bus_addr), .BUS_RRQ(bus_rrq), .BUS_RDY(bus_rdy), .BUS_DI(bus_di),
        .FIFO_DATA(fifo_data), .FIFO_VALID(fifo_valid), .FIFO_POP(fifo_pop), .FIFO_LEVEL(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Arbiter: RDY drops after a request, stays low arb_lat cycles, then returns addr[7:0].
    initial begin
        forever begin
            @(negedge clk);
            arb_deliver = 1'b0;
            if (rst) begin
                bus_rdy  = 1'b1;
                arb_busy = 1'b0;
            end else if (arb_busy) begin
                check("rrq_during_read", 32'(bus_rrq), 0);
                if (!arb_hold) begin
                    if (arb_cnt == 0) begin
                        bus_rdy          = 1'b1;
                        bus_di           = arb_addr[7:0];
                        arb_busy         = 1'b0;
                        arb_deliver      = 1'b1;
                        deliveries++;
                        last_deliver_cyc = cyc;
                    end else begin
                        arb_cnt--;
                    end
                end
            end else if (bus_rrq) begin
                check("rrq_addr", 32'(bus_addr), 32'(24'(burst_base + 24'(rrq_count - rrq_base))));
                addr_log.push_back(bus_addr);
                rrq_count++;
                arb_addr = bus_addr;
                bus_rdy  = 1'b0;
                arb_cnt  = arb_lat - 1;
                arb_busy = 1'b1;
            end
        end
    end

    // Scoreboard: every returned byte not cancelled by an abort is queued; aborts empty the queue.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                model_q.delete();
                cancelled = 1'b0;
            end else begin
                if (cmd_abort) begin
                    model_q.delete();
                    if (arb_deliver)
                        cancelled = 1'b0;
                    else if (arb_busy)
                        cancelled = 1'b1;
                end else begin
                    if (fifo_pop && model_q.size() > 0)
                        popped.push_back(model_q.pop_front());
                    if (arb_deliver) begin
                        if (cancelled || ignore_delivery)
                            cancelled = 1'b0;
                        else
                            model_q.push_back(bus_di);
                    end
                end
                check("level", 32'(fifo_level), model_q.size());
                check("valid", 32'(fifo_valid), 32'(model_q.size() != 0));
                if (model_q.size() != 0)
                    check("data", 32'(fifo_data), 32'(model_q[0]));
`ifndef CX4_FETCH_TIMEOUT_EN
                check("err", 32'(err), 0);
`endif
            end
        end
    end

    task automatic applyStimulus(input logic [23:0] a, input logic [15:0] n);
        burst_base = a;
        rrq_base   = rrq_count;
        tick();
        cmd_addr  = a;
        cmd_len   = n;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask

    task automatic checkOutput(input string name, input int limit, output int fall_cyc);
        int n = 0;
        while (cmd_busy && n < limit) begin
            tick();
            n++;
        end
        check(name, 32'(cmd_busy), 0);
        fall_cyc = cyc;
    endtask

    initial begin
        int fall;
        int base_pop;
        int base_log;
        int n;
        logic [23:0] wrap_exp [3];
        wrap_exp = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000};

        repeat (3) tick();
        check("rst_rrq", 32'(bus_rrq), 0);
        check("rst_addr", 32'(bus_addr), 0);
        check("rst_busy", 32'(cmd_busy), 0);
        check("rst_err", 32'(err), 0);
        check("rst_valid", 32'(fifo_valid), 0);
        check("rst_level", 32'(fifo_level), 0);
        check("rst_data", 32'(fifo_data), 0);
        rst = 1'b0;
        tick();

        // Basic burst
        arb_lat  = 7;
        fifo_pop = 1'b1;
        base_pop = popped.size();
        applyStimulus(24'h0A1000, 16'd4);
        check("basic_first_rrq", 32'(bus_rrq), 1);
        check("basic_busy", 32'(cmd_busy), 1);
        checkOutput("basic_done", 300, fall);
        check("basic_rrq_count", rrq_count - rrq_base, 4);
        check("basic_busy_fall", fall, last_deliver_cyc + 1);
        repeat (2) tick();
        check("basic_pop_count", popped.size() - base_pop, 4);
        if (popped.size() >= base_pop + 4)
            for (int i = 0; i < 4; i++)
                check("basic_data", 32'(popped[base_pop + i]), i);

        // Backpressure
        fifo_pop = 1'b0;
        arb_lat  = 3;
        applyStimulus(24'h001000, 16'd20);
        repeat (100) tick();
        check("bp_rrq8", rrq_count - rrq_base, 8);
        check("bp_level8", 32'(fifo_level), 8);
        check("bp_busy", 32'(cmd_busy), 1);
        check("bp_head0", 32'(fifo_data), 32'h00);
        fifo_pop = 1'b1;
        tick();
        fifo_pop = 1'b0;
        repeat (40) tick();
        check("bp_rrq9", rrq_count - rrq_base, 9);
        check("bp_level_after_pop", 32'(fifo_level), 8);
        check("bp_head1", 32'(fifo_data), 32'h01);
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        check("bp_abort_busy", 32'(cmd_busy), 0);
        check("bp_abort_level", 32'(fifo_level), 0);

        // Address wrap
        fifo_pop = 1'b1;
        arb_lat  = 2;
        base_log = addr_log.size();
        applyStimulus(24'hFFFFFE, 16'd3);
        checkOutput("wrap_done", 100, fall);
        check("wrap_rrq_count", rrq_count - rrq_base, 3);
        if (addr_log.size() >= base_log + 3)
            for (int i = 0; i < 3; i++)
                check("wrap_addr", 32'(addr_log[base_log + i]), 32'(wrap_exp[i]));
        check("wrap_final_addr", 32'(bus_addr), 32'h000001);
        repeat (2) tick();

        // Abort while the second read is in flight
        fifo_pop = 1'b0;
        arb_lat  = 7;
        applyStimulus(24'h000100, 16'd5);
        n = 0;
        while ((rrq_count - rrq_base) < 2 && n < 100) begin
            tick();
            n++;
        end
        check("abort_second_rrq", rrq_count - rrq_base, 2);
        check("abort_level_before", 32'(fifo_level), 1);
        repeat (3) tick();
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        check("abort_level", 32'(fifo_level), 0);
        check("abort_valid", 32'(fifo_valid), 0);
        check("abort_draining", 32'(cmd_busy), 1);
        checkOutput("abort_done", 50, fall);
        check("abort_busy_fall", fall, last_deliver_cyc + 1);
        repeat (20) tick();
        check("abort_no_more_rrq", rrq_count - rrq_base, 2);
        check("abort_level_after", 32'(fifo_level), 0);

        // Zero-length start is a no-op
        applyStimulus(24'h123456, 16'd0);
        check("noop_rrq", 32'(bus_rrq), 0);
        check("noop_busy", 32'(cmd_busy), 0);
        repeat (10) tick();
        check("noop_rrq_count", rrq_count - rrq_base, 0);

        // Second start mid-burst is ignored
        fifo_pop = 1'b1;
        arb_lat  = 4;
        base_pop = popped.size();
        applyStimulus(24'h200000, 16'd3);
        repeat (2) tick();
        cmd_addr  = 24'h777777;
        cmd_len   = 16'd9;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        checkOutput("restart_done", 100, fall);
        check("restart_rrq_count", rrq_count - rrq_base, 3);
        repeat (2) tick();
        check("restart_pop_count", popped.size() - base_pop, 3);
        if (popped.size() >= base_pop + 3)
            for (int i = 0; i < 3; i++)
                check("restart_data", 32'(popped[base_pop + i]), i);

        // Arbiter never returns data
        fifo_pop = 1'b0;
        arb_hold = 1'b1;
        applyStimulus(24'h300000, 16'd2);
        repeat (300) tick();
        check("hold_rrq_count", rrq_count - rrq_base, 1);
`ifdef CX4_FETCH_TIMEOUT_EN
        check("timeout_err", 32'(err), 1);
        check("timeout_idle", 32'(cmd_busy), 0);
        check("timeout_level", 32'(fifo_level), 0);
        ignore_delivery = 1'b1;
        arb_hold = 1'b0;
        repeat (10) tick();
        ignore_delivery = 1'b0;
        check("timeout_err_sticky", 32'(err), 1);
        check("timeout_level_after", 32'(fifo_level), 0);
`else
        check("hold_err", 32'(err), 0);
        check("hold_busy", 32'(cmd_busy), 1);
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        arb_hold = 1'b0;
        checkOutput("hold_drain_done", 50, fall);
        check("hold_level_after", 32'(fifo_level), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL sim_timeout: got still running want finished");
        $fatal(1);
    end

endmodule
